// File: rtl/vend_controller.sv
// Vending transaction sequencer: collects 5/10/25 coins, requests a vend, then pays change or refunds.
// Coin to VEND is one edge; the vend and change handshakes hold their requests until acknowledged.
module vend_controller #(
  parameter int PRICE_UNITS  = 5,
  parameter int CREDIT_W     = 5,
  parameter int MAX_CREDIT   = 20,
  parameter int VEND_TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fiveKurus,
  input  logic                tenCents,
  input  logic                twentyFiveKurus,
  input  logic                cancel,
  input  logic                vendAck,
  input  logic                changeAck,
  output logic                vendReq,
  output logic                changeReq,
  output logic                coinReject,
  output logic                vendFail,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [15:0]         salesCount
);

  localparam int TIMER_W = $clog2(VEND_TIMEOUT + 1);
  localparam logic [CREDIT_W:0]   MaxCreditWide = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PriceWide     = (CREDIT_W+1)'(PRICE_UNITS);
  localparam logic [CREDIT_W-1:0] Price         = CREDIT_W'(PRICE_UNITS);
  localparam logic [TIMER_W-1:0]  TimeoutLast   = TIMER_W'(VEND_TIMEOUT - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [1:0]           coinCount;
  logic                 anyCoin;
  logic                 oneCoin;
  logic [CREDIT_W:0]    coinValue;
  logic [CREDIT_W:0]    creditSum;

  assign coinCount = {1'b0, fiveKurus} + {1'b0, tenCents} + {1'b0, twentyFiveKurus};
  assign anyCoin   = (coinCount != 2'd0);
  assign oneCoin   = (coinCount == 2'd1);

  always_comb begin
    coinValue = '0;
    if (fiveKurus)       coinValue = (CREDIT_W+1)'(1);
    if (tenCents)        coinValue = (CREDIT_W+1)'(2);
    if (twentyFiveKurus) coinValue = (CREDIT_W+1)'(5);
  end

  // One extra bit so an overflowing coin is detected instead of wrapping.
  assign creditSum = {1'b0, credit} + coinValue;

  assign vendReq   = (state == VEND);
  assign changeReq = (state == CHANGE);
  assign busy      = (state != COLLECT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= COLLECT;
      credit     <= '0;
      salesCount <= '0;
      timer      <= '0;
      coinReject <= 1'b0;
      vendFail   <= 1'b0;
    end else begin
      coinReject <= 1'b0;
      vendFail   <= 1'b0;
      case (state)
        COLLECT: begin
          if (cancel && credit != '0) begin
            state      <= CHANGE;
            coinReject <= anyCoin;
          end else if (anyCoin) begin
            if (!oneCoin || creditSum > MaxCreditWide) begin
              coinReject <= 1'b1;
            end else begin
              credit <= creditSum[CREDIT_W-1:0];
              if (creditSum >= PriceWide) begin
                state <= VEND;
                timer <= '0;
              end
            end
          end
        end
        VEND: begin
          coinReject <= anyCoin;
          if (vendAck) begin
            credit     <= credit - Price;
            salesCount <= salesCount + 16'd1;
            state      <= (credit != Price) ? CHANGE : COLLECT;
          end else if (timer == TimeoutLast) begin
            // Dispenser never answered: keep the full credit and refund it.
            vendFail <= 1'b1;
            state    <= CHANGE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        CHANGE: begin
          coinReject <= anyCoin;
          if (credit == '0) begin
            state <= COLLECT;
          end else if (changeAck) begin
            credit <= credit - CREDIT_W'(1);
            if (credit == CREDIT_W'(1)) state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed table, corner sequences, randomized model check.
module tb_vend_controller;

  localparam int PRICE = 5;
  localparam int MAXC  = 20;
  localparam int TMO   = 255;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic fiveKurus = 0, tenCents = 0, twentyFiveKurus = 0, cancel = 0, vendAck = 0, changeAck = 0;
  logic vendReq, changeReq, coinReject, vendFail, busy;
  logic [4:0]  credit;
  logic [15:0] salesCount;
  logic bVendReq, bChangeReq, bCoinReject, bVendFail, bBusy;
  logic [4:0]  bCredit;
  logic [15:0] bSalesCount;

  vend_controller #(.PRICE_UNITS(PRICE), .CREDIT_W(5), .MAX_CREDIT(MAXC), .VEND_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .fiveKurus(fiveKurus), .tenCents(tenCents),
    .twentyFiveKurus(twentyFiveKurus), .cancel(cancel), .vendAck(vendAck), .changeAck(changeAck),
    .vendReq(vendReq), .changeReq(changeReq), .coinReject(coinReject), .vendFail(vendFail),
    .busy(busy), .credit(credit), .salesCount(salesCount));

  // Price above the credit ceiling, so credit can climb to MAX_CREDIT without vending.
  vend_controller #(.PRICE_UNITS(21), .CREDIT_W(5), .MAX_CREDIT(MAXC), .VEND_TIMEOUT(TMO)) dutB (
    .clock(clock), .reset(reset), .fiveKurus(fiveKurus), .tenCents(tenCents),
    .twentyFiveKurus(twentyFiveKurus), .cancel(cancel), .vendAck(vendAck), .changeAck(changeAck),
    .vendReq(bVendReq), .changeReq(bChangeReq), .coinReject(bCoinReject), .vendFail(bVendFail),
    .busy(bBusy), .credit(bCredit), .salesCount(bSalesCount));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the customer's view of the machine.
  localparam int M_IDLE = 0, M_DISPENSE = 1, M_REFUND = 2;
  int mPhase, mCredit, mSales, mWait;
  bit mReject, mFail;

  task automatic modelReset();
    mPhase = M_IDLE; mCredit = 0; mSales = 0; mWait = 0; mReject = 0; mFail = 0;
  endtask

  task automatic modelStep(input bit f, input bit t, input bit q, input bit c, input bit va, input bit ca);
    int n, val;
    n = int'(f) + int'(t) + int'(q);
    val = (f ? 1 : 0) + (t ? 2 : 0) + (q ? 5 : 0);
    mReject = 0;
    mFail = 0;
    if (mPhase == M_IDLE) begin
      if (c && mCredit > 0) begin
        mReject = (n > 0);
        mPhase = M_REFUND;
      end else if (n > 1) begin
        mReject = 1;
      end else if (n == 1) begin
        if (mCredit + val > MAXC) mReject = 1;
        else begin
          mCredit += val;
          if (mCredit >= PRICE) begin mPhase = M_DISPENSE; mWait = 0; end
        end
      end
    end else if (mPhase == M_DISPENSE) begin
      mReject = (n > 0);
      if (va) begin
        mCredit -= PRICE;
        mSales = (mSales + 1) % 65536;
        mPhase = (mCredit > 0) ? M_REFUND : M_IDLE;
      end else begin
        mWait++;
        if (mWait == TMO) begin mFail = 1; mPhase = M_REFUND; end
      end
    end else begin
      mReject = (n > 0);
      if (ca) begin
        mCredit--;
        if (mCredit == 0) mPhase = M_IDLE;
      end
    end
  endtask

  task automatic drive(input bit f, input bit t, input bit q, input bit c, input bit va, input bit ca);
    fiveKurus = f; tenCents = t; twentyFiveKurus = q; cancel = c; vendAck = va; changeAck = ca;
    modelStep(f, t, q, c, va, ca);
    @(posedge clock);
    #1;
    fiveKurus = 0; tenCents = 0; twentyFiveKurus = 0; cancel = 0; vendAck = 0; changeAck = 0;
  endtask

  task automatic checkModel(input string tag);
    chk({tag, ".credit"},     credit,     mCredit);
    chk({tag, ".sales"},      salesCount, mSales);
    chk({tag, ".vendReq"},    vendReq,    mPhase == M_DISPENSE);
    chk({tag, ".changeReq"},  changeReq,  mPhase == M_REFUND);
    chk({tag, ".busy"},       busy,       mPhase != M_IDLE);
    chk({tag, ".coinReject"}, coinReject, mReject);
    chk({tag, ".vendFail"},   vendFail,   mFail);
  endtask

  task automatic doReset();
    reset = 0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    bit f, t, q, c, va, ca;
    int cr;
    bit vr, chr, rej;
    int sales;
  } vec_t;

  vec_t tbl[22];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n;
    //            f t q c va ca  credit vreq creq rej sales
    tbl[0]  = '{0,1,0,0,0,0, 2, 0,0,0, 0};
    tbl[1]  = '{0,1,0,0,0,0, 4, 0,0,0, 0};
    tbl[2]  = '{1,0,0,0,0,0, 5, 1,0,0, 0};
    tbl[3]  = '{0,0,0,0,0,0, 5, 1,0,0, 0};
    tbl[4]  = '{0,0,0,0,0,0, 5, 1,0,0, 0};
    tbl[5]  = '{0,0,0,0,1,0, 0, 0,0,0, 1};
    tbl[6]  = '{0,0,1,0,0,0, 5, 1,0,0, 1};
    tbl[7]  = '{0,1,0,0,0,0, 5, 1,0,1, 1};
    tbl[8]  = '{0,0,0,0,1,0, 0, 0,0,0, 2};
    tbl[9]  = '{0,1,0,0,0,0, 2, 0,0,0, 2};
    tbl[10] = '{0,1,0,0,0,0, 4, 0,0,0, 2};
    tbl[11] = '{0,1,0,0,0,0, 6, 1,0,0, 2};
    tbl[12] = '{0,0,0,0,1,0, 1, 0,1,0, 3};
    tbl[13] = '{0,0,0,0,0,1, 0, 0,0,0, 3};
    tbl[14] = '{1,0,0,0,0,0, 1, 0,0,0, 3};
    tbl[15] = '{0,1,0,0,0,0, 3, 0,0,0, 3};
    tbl[16] = '{0,0,0,1,0,0, 3, 0,1,0, 3};
    tbl[17] = '{0,0,0,0,0,1, 2, 0,1,0, 3};
    tbl[18] = '{0,0,0,0,0,1, 1, 0,1,0, 3};
    tbl[19] = '{0,0,0,0,0,1, 0, 0,0,0, 3};
    tbl[20] = '{1,1,0,0,0,0, 0, 0,0,1, 3};
    tbl[21] = '{0,0,0,1,0,0, 0, 0,0,0, 3};

    doReset();
    chk("reset.credit", credit, 0);
    chk("reset.busy", busy, 0);
    chk("reset.vendReq", vendReq, 0);
    chk("reset.changeReq", changeReq, 0);
    chk("reset.sales", salesCount, 0);
    chk("reset.coinReject", coinReject, 0);
    chk("reset.vendFail", vendFail, 0);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].f, tbl[i].t, tbl[i].q, tbl[i].c, tbl[i].va, tbl[i].ca);
      chk($sformatf("vec%0d.credit", i), credit, tbl[i].cr);
      chk($sformatf("vec%0d.vendReq", i), vendReq, tbl[i].vr);
      chk($sformatf("vec%0d.changeReq", i), changeReq, tbl[i].chr);
      chk($sformatf("vec%0d.coinReject", i), coinReject, tbl[i].rej);
      chk($sformatf("vec%0d.sales", i), salesCount, tbl[i].sales);
    end

    // Dispenser timeout and full refund.
    doReset();
    drive(0, 0, 1, 0, 0, 0);
    chk("tmo.enterVend", vendReq, 1);
    n = 0;
    while (!vendFail && n < 400) begin
      drive(0, 0, 0, 0, 0, 0);
      n++;
      checkModel("tmo");
    end
    chk("tmo.cycles", n, TMO);
    chk("tmo.changeReq", changeReq, 1);
    chk("tmo.credit", credit, 5);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk($sformatf("tmo.refund%0d", i), credit, 4 - i);
    end
    chk("tmo.sales", salesCount, 0);
    chk("tmo.idle", busy, 0);

    // Reset asserted mid-refund acts immediately.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("rstMid.changeReq", changeReq, 1);
    #2;
    reset = 0;
    modelReset();
    #1;
    chk("rstMid.credit", credit, 0);
    chk("rstMid.changeReq", changeReq, 0);
    chk("rstMid.busy", busy, 0);
    @(posedge clock);
    #1;
    reset = 1;

    // Credit ceiling on the high-price instance.
    doReset();
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("max.credit19", bCredit, 19);
    drive(0, 1, 0, 0, 0, 0);
    chk("max.reject10", bCoinReject, 1);
    chk("max.keep19", bCredit, 19);
    drive(1, 0, 0, 0, 0, 0);
    chk("max.accept5", bCoinReject, 0);
    chk("max.credit20", bCredit, 20);
    drive(1, 0, 0, 0, 0, 0);
    chk("max.rejectFull", bCoinReject, 1);
    chk("max.busy", bBusy, 0);

    // Randomized traffic against the reference model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) < 15, $urandom_range(99) < 15, $urandom_range(99) < 10,
            $urandom_range(99) < 5, $urandom_range(99) < 12, $urandom_range(99) < 35);
      checkModel("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Transaction sequencer for the coin-operated vending datapath: accepts 5/10/25 coin pulses, accumulates credit, issues a handshaked vend request to the product dispenser, then pays change or refunds through a handshaked 5-unit change dispenser.
- Adds the following on top of the bare coin-counting FSM: a cancel/refund path, a dispenser timeout, coin rejection while busy or on overflow, and a sales counter.
- Sits between the coin acceptor front-end and the dispenser/change mechanics.

Parameters:
- PRICE_UNITS, 5, product price in 5-unit coins (default 25).
- CREDIT_W, 5, credit register width.
- MAX_CREDIT, 20, highest credit accepted, in units; must be < 2**CREDIT_W.
- VEND_TIMEOUT, 255, cycles to wait for vendAck before aborting.

Ports:
- clock, in, 1: sole clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-low; low forces reset state immediately.
- fiveKurus, in, 1: 1-cycle coin pulse, value 1 unit.
- tenCents, in, 1: 1-cycle coin pulse, value 2 units.
- twentyFiveKurus, in, 1: 1-cycle coin pulse, value 5 units.
- cancel, in, 1: 1-cycle refund request.
- vendAck, in, 1: dispenser has released the product.
- changeAck, in, 1: change unit has ejected one 5-unit coin.
- vendReq, out, 1: request product release.
- changeReq, out, 1: request one change coin.
- coinReject, out, 1: registered 1-cycle pulse; offending coin is returned physically.
- vendFail, out, 1: registered 1-cycle pulse on dispenser timeout.
- busy, out, 1: high in any state other than COLLECT.
- credit, out, CREDIT_W: current credit in units.
- salesCount, out, 16: completed vends, wraps at 65535→0.

Behaviour:
- Reset: state=COLLECT. credit, salesCount and the timeout counter are 0. All 1-bit outputs are 0.
- Valid coin: exactly one coin input high. Two or more coin inputs high in one cycle → coinReject next cycle, credit unchanged.
- Moore outputs: vendReq=(state==VEND), changeReq=(state==CHANGE), busy=(state!=COLLECT). All are registered via state; there is no combinational input→output path.
- COLLECT:
  - cancel high with credit>0 → go to CHANGE (refund). A coin in the same cycle is rejected; cancel wins.
  - cancel high with credit==0 → ignored.
  - Valid coin with credit+value > MAX_CREDIT → coinReject, credit unchanged.
  - Otherwise credit ← credit+value, computed at CREDIT_W+1 bits to avoid wrap. If the new credit ≥ PRICE_UNITS → go to VEND next cycle.
- VEND:
  - Timeout counter clears on entry.
  - vendReq is held high until vendAck is sampled high.
  - On vendAck: credit ← credit−PRICE_UNITS, salesCount+1. Go to CHANGE if the remainder > 0, else COLLECT.
  - If the counter reaches VEND_TIMEOUT with no ack: vendFail pulse, credit unchanged, go to CHANGE (full refund), salesCount unchanged.
- CHANGE:
  - changeReq is held high. Each cycle with changeAck high: credit ← credit−1.
  - When the decrement makes credit 0 → COLLECT in the same edge; changeReq drops next cycle.
  - changeAck in any other state is ignored.
- Coins in VEND or CHANGE → coinReject, no credit change. cancel in VEND or CHANGE is ignored.
- vendAck outside VEND is ignored. vendAck and timeout in the same cycle: ack wins.
- Latency: coin to VEND is 1 edge. vendAck to CHANGE/COLLECT is 1 edge. Minimum COLLECT→COLLECT round trip for an exact-price purchase is 2 edges plus the dispenser latency.
- Reset asserted mid-transaction: state returns to COLLECT and credit is lost. This is an accepted design point; no state is preserved.
- States are encoded in a typed enum with a default arm going to COLLECT.

Test Plan:
- Reset low, then release, all inputs 0 → credit=0, busy=0, vendReq=0, salesCount=0.
- Coins 10,10,5 in consecutive cycles → credit 2,4,5; vendReq high one edge after the third coin; vendAck after 3 cycles → credit=0, salesCount=1, changeReq never asserts.
- Coins 25,10 → 10 is rejected (busy in VEND). Repeat from COLLECT with 10,10,10 (credit 6) → vend; after vendAck credit=1, changeReq high; one changeAck → credit=0, state COLLECT.
- Coins 5,10 then cancel → changeReq high; three changeAck pulses → credit 2,1,0; no vendReq, salesCount unchanged.
- 25 inserted, vendAck withheld 255 cycles → vendFail pulse; changeReq refunds 5 units via 5 changeAck pulses; salesCount unchanged.
- fiveKurus and tenCents high in the same cycle → coinReject=1 next cycle, credit unchanged. Credit 19 plus a 10 coin with MAX_CREDIT=20 → coinReject. Assert reset during CHANGE → credit=0, changeReq=0 immediately.
